// File: rtl/flit_injector.sv
// Queues packet descriptors and injects their flits, one per injection slot, into the router local port.
// Latency: first flit registered on the 3rd edge after a push into an idle block; backpressure: pkt_ready low when the FIFO is full, flits stall on inject_en/can_inject.
module flit_injector #(
    parameter int MAXVC  = 4,
    parameter int DST_W  = 14,
    parameter int CYC_W  = 16,
    parameter int QDEPTH = 8,
    parameter int LEN_W  = 4,
    localparam int VC_W   = (MAXVC > 1) ? $clog2(MAXVC) : 1,
    localparam int FLIT_W = 3 + VC_W + DST_W + CYC_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pkt_valid,
    output logic              pkt_ready,
    input  logic [DST_W-1:0]  pkt_dst,
    input  logic [VC_W-1:0]   pkt_vc,
    input  logic [LEN_W-1:0]  pkt_len,
    input  logic              inject_en,
    input  logic [CYC_W-1:0]  cur_cycle,
    input  logic [MAXVC-1:0]  can_inject,
    output logic [FLIT_W-1:0] inj_flit,
    output logic              idle,
    output logic [31:0]       flit_count
);
    localparam int AW     = $clog2(QDEPTH);
    localparam int DESC_W = DST_W + VC_W + LEN_W;

    typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;

    state_t            state_q, state_d;
    logic [AW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DESC_W-1:0] mem_q [QDEPTH];
    logic [VC_W-1:0]   vc_q, vc_d;
    logic [DST_W-1:0]  dst_q, dst_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic              first_q, first_d;
    logic [FLIT_W-1:0] inj_flit_q, inj_flit_d;
    logic [31:0]       flit_count_q, flit_count_d;

    logic              full, empty, push, emit;
    logic [DST_W-1:0]  hd_dst;
    logic [VC_W-1:0]   hd_vc;
    logic [LEN_W-1:0]  hd_len;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign full  = (wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}};
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign push  = pkt_valid && !full;
    assign emit  = (state_q == SEND) && inject_en && can_inject[vc_q];

    assign {hd_dst, hd_vc, hd_len} = mem_q[rd_ptr_q[AW-1:0]];

    assign pkt_ready  = !full;
    assign idle       = (state_q == IDLE) && empty;
    assign inj_flit   = inj_flit_q;
    assign flit_count = flit_count_q;

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        vc_d         = vc_q;
        dst_d        = dst_q;
        rem_d        = rem_q;
        first_d      = first_q;
        inj_flit_d   = '0;
        flit_count_d = flit_count_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (!empty) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                vc_d     = hd_vc;
                dst_d    = hd_dst;
                rem_d    = (hd_len == '0) ? LEN_W'(1) : hd_len;
                first_d  = 1'b1;
                rd_ptr_d = rd_ptr_q + 1'b1;
                state_d  = SEND;
            end
            SEND: begin
                if (emit) begin
                    inj_flit_d   = {1'b1, vc_q, first_q, (rem_q == LEN_W'(1)), dst_q, cur_cycle};
                    flit_count_d = flit_count_q + 32'd1;
                    first_d      = 1'b0;
                    if (rem_q != '0) begin
                        rem_d = rem_q - LEN_W'(1);
                    end
                    if (rem_q <= LEN_W'(1)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            vc_q         <= '0;
            dst_q        <= '0;
            rem_q        <= '0;
            first_q      <= 1'b0;
            inj_flit_q   <= '0;
            flit_count_q <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            vc_q         <= vc_d;
            dst_q        <= dst_d;
            rem_q        <= rem_d;
            first_q      <= first_d;
            inj_flit_q   <= inj_flit_d;
            flit_count_q <= flit_count_d;
        end
    end

    // Descriptor storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {pkt_dst, pkt_vc, pkt_len};
        end
    end
endmodule

// File: tb/tb_flit_injector.sv
// Randomized and directed bench for flit_injector against a packet-level reference model.
module tb_flit_injector;
    localparam int MAXVC  = 4;
    localparam int DST_W  = 14;
    localparam int CYC_W  = 16;
    localparam int QDEPTH = 8;
    localparam int LEN_W  = 4;
    localparam int VC_W   = 2;
    localparam int FW     = 3 + VC_W + DST_W + CYC_W;
    localparam int HEAD_B = CYC_W + DST_W + 1;
    localparam int TAIL_B = CYC_W + DST_W;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             pkt_valid = 1'b0;
    logic             pkt_ready;
    logic [DST_W-1:0] pkt_dst = '0;
    logic [VC_W-1:0]  pkt_vc = '0;
    logic [LEN_W-1:0] pkt_len = '0;
    logic             inject_en = 1'b0;
    logic [CYC_W-1:0] cur_cycle = '0;
    logic [MAXVC-1:0] can_inject = '0;
    logic [FW-1:0]    inj_flit;
    logic             idle;
    logic [31:0]      flit_count;

    always #5 clk = ~clk;

    flit_injector #(.MAXVC(MAXVC), .DST_W(DST_W), .CYC_W(CYC_W), .QDEPTH(QDEPTH), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst_n(rst_n), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
        .pkt_dst(pkt_dst), .pkt_vc(pkt_vc), .pkt_len(pkt_len), .inject_en(inject_en),
        .cur_cycle(cur_cycle), .can_inject(can_inject), .inj_flit(inj_flit),
        .idle(idle), .flit_count(flit_count)
    );

    typedef struct {
        logic [DST_W-1:0] dst;
        logic [VC_W-1:0]  vc;
        logic [LEN_W-1:0] len;
        int               pe;
    } desc_t;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: queued descriptors, packet in flight, edge of the last tail.
    desc_t            mq[$];
    bit               m_act = 1'b0;
    logic [DST_W-1:0] m_dst;
    logic [VC_W-1:0]  m_vc;
    int               m_rem;
    bit               m_first;
    int               m_done = -100;
    logic [FW-1:0]    exp_flit = '0;
    logic [31:0]      exp_cnt = '0;
    int               edge_n = 0;
    int               pp7 = 0;

    desc_t         host_q[$];
    int            host_gate = 100;
    int            host_acc = 0;
    bit            rdy_seen = 1'b0;
    int            net_mode = 2;
    int            net_cyc = 0;
    int            cyc_base = 0;
    int            strobe_at = 0;
    int            arm_base = 0;
    bit            armed = 1'b0;
    int            blk_left = 0;
    logic [FW-1:0] flog[$];
    int            mon_flits = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit acc, was_act, popped;
        int occ, lim;
        edge_n++;
        if (!rst_n) begin
            mq.delete();
            m_act    = 1'b0;
            m_done   = -100;
            exp_flit = '0;
            exp_cnt  = '0;
            return;
        end
        occ     = mq.size();
        was_act = m_act;
        acc     = pkt_valid && (occ < QDEPTH);
        popped  = 1'b0;
        exp_flit = '0;
        if (m_act && inject_en && can_inject[m_vc]) begin
            exp_flit = {1'b1, m_vc, m_first, (m_rem == 1), m_dst, cur_cycle};
            m_first  = 1'b0;
            m_rem--;
            exp_cnt++;
            if (m_rem == 0) begin
                m_act  = 1'b0;
                m_done = edge_n;
            end
        end
        if (!was_act && occ > 0) begin
            // A descriptor spends one cycle in IDLE->LOAD and is popped on the next edge.
            lim = ((m_done > mq[0].pe) ? m_done : mq[0].pe) + 2;
            if (edge_n >= lim) begin
                m_dst   = mq[0].dst;
                m_vc    = mq[0].vc;
                m_rem   = (mq[0].len == 0) ? 1 : int'(mq[0].len);
                m_first = 1'b1;
                m_act   = 1'b1;
                popped  = 1'b1;
                void'(mq.pop_front());
            end
        end
        if (acc) mq.push_back('{pkt_dst, pkt_vc, pkt_len, edge_n});
        if (acc && popped && occ == QDEPTH - 1) pp7++;
    endtask

    task automatic drive_net();
        net_cyc++;
        cur_cycle = CYC_W'(net_cyc - cyc_base);
        if (net_mode != 3) armed = 1'b0;
        case (net_mode)
            0: begin
                inject_en = ($urandom_range(0, 99) < 60);
                for (int i = 0; i < MAXVC; i++) can_inject[i] = ($urandom_range(0, 3) != 0);
            end
            1: begin
                inject_en  = (int'(cur_cycle) == strobe_at);
                can_inject = '1;
            end
            3: begin
                if (!armed && (mon_flits - arm_base) == 1) begin
                    armed    = 1'b1;
                    blk_left = 3;
                end
                inject_en  = 1'b1;
                can_inject = (blk_left > 0) ? 4'b1011 : 4'b1111;
                if (blk_left > 0) blk_left--;
            end
            4: begin
                inject_en  = 1'b1;
                can_inject = '1;
            end
            default: begin
                inject_en  = 1'b0;
                can_inject = '1;
            end
        endcase
    endtask

    task automatic host_step();
        if (pkt_valid && rdy_seen) begin
            void'(host_q.pop_front());
            host_acc++;
        end
        if (host_q.size() > 0 && $urandom_range(0, 99) < host_gate) begin
            pkt_valid = 1'b1;
            pkt_dst   = host_q[0].dst;
            pkt_vc    = host_q[0].vc;
            pkt_len   = host_q[0].len;
        end else begin
            pkt_valid = 1'b0;
        end
        rdy_seen = pkt_ready;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("inj_flit", inj_flit, exp_flit);
        check("pkt_ready", pkt_ready, mq.size() < QDEPTH);
        check("idle", idle, mq.size() == 0 && !m_act);
        check("flit_count", flit_count, exp_cnt);
        if (inj_flit[FW-1]) begin
            flog.push_back(inj_flit);
            mon_flits++;
        end
        @(negedge clk);
        drive_net();
        host_step();
    endtask

    task automatic push_desc(input int dst, input int vc, input int len);
        host_q.push_back('{DST_W'(dst), VC_W'(vc), LEN_W'(len), 0});
    endtask

    function automatic bit quiet();
        return host_q.size() == 0 && !pkt_valid && mq.size() == 0 && !m_act;
    endfunction

    task automatic drain(input string nm, input int budget);
        int k = 0;
        while (!quiet() && k < budget) begin
            tick();
            k++;
        end
        tick();
        check(nm, quiet(), 1);
    endtask

    initial begin
        int b, a0, k, span;
        logic [FW-1:0] want, got;
        logic [3:0] heads, tails;

        repeat (3) tick();
        rst_n = 1'b1;

        // Single 1-flit packet, strobe at cycle 5.
        net_mode = 1; strobe_at = 5; cyc_base = net_cyc; b = flog.size();
        push_desc(12, 1, 1);
        repeat (12) tick();
        want = {1'b1, 2'd1, 1'b1, 1'b1, 14'd12, 16'd5};
        got  = (flog.size() > b) ? flog[b] : '0;
        check("a_nflits", flog.size() - b, 1);
        check("a_flit", got, want);
        check("a_flit_count", flit_count, 1);
        check("a_idle", idle, 1);

        // Zero-length descriptor is one head+tail flit.
        cyc_base = net_cyc; b = flog.size();
        push_desc(5, 3, 0);
        repeat (12) tick();
        want = {1'b1, 2'd3, 1'b1, 1'b1, 14'd5, 16'd5};
        got  = (flog.size() > b) ? flog[b] : '0;
        check("b_flit", got, want);
        check("b_flit_count", flit_count, 2);

        // 4-flit packet on vc 2 blocked for three strobes after its first flit.
        net_mode = 3; arm_base = mon_flits; b = flog.size();
        push_desc(100, 2, 4);
        drain("c_drain", 60);
        heads = '0; tails = '0;
        for (int i = 0; i < 4; i++) begin
            if (b + i < flog.size()) begin
                heads[i] = flog[b+i][HEAD_B];
                tails[i] = flog[b+i][TAIL_B];
            end
        end
        span = (flog.size() >= b + 4) ? int'(flog[b+3][CYC_W-1:0]) - int'(flog[b][CYC_W-1:0]) : -1;
        check("c_nflits", flog.size() - b, 4);
        check("c_heads", heads, 4'b0001);
        check("c_tails", tails, 4'b1000);
        check("c_ts_span", span, 6);

        // Fill the FIFO behind a stalled packet; the ninth push waits for a pop.
        net_mode = 2;
        push_desc(7, 0, 2);
        repeat (5) tick();
        a0 = host_acc;
        for (int i = 0; i < QDEPTH + 1; i++) push_desc($urandom_range(0, 16383), $urandom_range(0, 3), $urandom_range(0, 3));
        k = 0;
        do begin
            tick();
            k++;
        end while (pkt_ready && k < 30);
        check("d_accepts_at_full", host_acc - a0, QDEPTH);
        repeat (5) tick();
        check("d_held_ready", pkt_ready, 0);
        check("d_held_pending", host_q.size(), 1);
        net_mode = 0;
        drain("d_drain", 1500);
        check("d_all_accepted", host_acc - a0, QDEPTH + 1);

        // Producer faster than consumer: FIFO hovers at full, pointers wrap many times.
        net_mode = 4; host_gate = 45;
        for (int i = 0; i < 100; i++) push_desc($urandom_range(0, 16383), $urandom_range(0, 3), $urandom_range(0, 2));
        drain("e_drain", 3000);
        check("e_pushpop_at_depth7", pp7 > 0, 1);

        // Fully random traffic.
        net_mode = 0; host_gate = 70;
        for (int i = 0; i < 40; i++) push_desc($urandom_range(0, 16383), $urandom_range(0, 3), $urandom_range(0, 15));
        drain("f_drain", 5000);

        // Reset during flit 2 of a 3-flit packet with two descriptors queued.
        net_mode = 4; host_gate = 100; b = flog.size();
        push_desc(33, 1, 3);
        push_desc(34, 2, 2);
        push_desc(35, 3, 2);
        k = 0;
        while (flog.size() - b < 2 && k < 40) begin
            tick();
            k++;
        end
        check("g_reached_flit2", flog.size() - b, 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("g_rst_flit", inj_flit, 0);
        check("g_rst_count", flit_count, 0);
        check("g_rst_ready", pkt_ready, 1);
        check("g_rst_idle", idle, 1);
        repeat (2) tick();
        rst_n = 1'b1;
        b = flog.size();
        repeat (20) tick();
        check("g_no_flits", flog.size() - b, 0);
        check("g_count_zero", flit_count, 0);
        push_desc(40, 0, 2);
        drain("g_drain", 60);
        check("g_new_count", flit_count, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
